// File: rtl/pdp_fetch_decode.sv
// pdp_fetch_decode: byte-wide instruction fetch and decode front end for a
// PDP-11 style core.
//
// Fetches 16-bit little-endian instruction words one byte at a time, decodes
// the mnemonic, fetches up to two extension words, and presents one decoded
// bundle to the execute stage with a valid/ready handshake.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   pc_load            redirect request from execute (branch/jump/RTS)
//   pc_load_val        redirect target (bit 0 is ignored)
//   mem_req/mem_addr   byte read request and byte address
//   mem_type           access type, always INSTRUCTION_FETCH (2)
//   mem_ack/mem_rdata  request accepted; read byte valid in the same cycle
//   dec_valid          decoded bundle valid (held until dec_ready)
//   dec_ready          execute stage accepts the bundle
//   dec_mnem           decoded mnemonic (NOP for illegal encodings)
//   dec_ir, dec_pc     instruction word and its address
//   dec_next_pc        address following the last extension word
//   dec_ext0/1         first/second extension word, 0 when absent
//   dec_illegal        unrecognised encoding

package pdp_pkg;

  typedef enum logic [6:0] {
    OP_HALT = 7'd0,
    OP_NOP,
    OP_MOV,  OP_MOVB, OP_CMP,  OP_CMPB, OP_BIT,  OP_BITB,
    OP_BIC,  OP_BICB, OP_BIS,  OP_BISB, OP_ADD,  OP_SUB,
    OP_BR,   OP_BNE,  OP_BEQ,  OP_BGE,  OP_BLT,  OP_BGT,  OP_BLE,
    OP_BPL,  OP_BMI,  OP_BHI,  OP_BLOS, OP_BVC,  OP_BVS,  OP_BCC,  OP_BCS,
    OP_JSR,  OP_RTS,  OP_JMP,  OP_SWAB,
    OP_CLR,  OP_CLRB, OP_COM,  OP_COMB, OP_INC,  OP_INCB, OP_DEC,  OP_DECB,
    OP_NEG,  OP_NEGB, OP_ADC,  OP_ADCB, OP_SBC,  OP_SBCB, OP_TST,  OP_TSTB,
    OP_ROR,  OP_RORB, OP_ROL,  OP_ROLB, OP_ASR,  OP_ASRB, OP_ASL,  OP_ASLB,
    OP_CLC,  OP_CLV,  OP_CLZ,  OP_CLN,  OP_SEC,  OP_SEV,  OP_SEZ,  OP_SEN
  } opcode_mnemonic;

  typedef struct packed {
    opcode_mnemonic mnem;
    logic           illegal;
    logic [1:0]     n_ext;
  } decode_t;

endpackage

module pdp_fetch_decode
  import pdp_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'o001000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pc_load,
  input  logic [15:0]    pc_load_val,
  output logic           mem_req,
  output logic [15:0]    mem_addr,
  output logic [1:0]     mem_type,
  input  logic           mem_ack,
  input  logic [7:0]     mem_rdata,
  output logic           dec_valid,
  input  logic           dec_ready,
  output opcode_mnemonic dec_mnem,
  output logic [15:0]    dec_ir,
  output logic [15:0]    dec_pc,
  output logic [15:0]    dec_next_pc,
  output logic [15:0]    dec_ext0,
  output logic [15:0]    dec_ext1,
  output logic           dec_illegal
);

  localparam logic [2:0] FETCH_LO = 3'd0;
  localparam logic [2:0] FETCH_HI = 3'd1;
  localparam logic [2:0] EXT_LO   = 3'd2;
  localparam logic [2:0] EXT_HI   = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;

  // An operand needs an extension word for index/index-deferred modes on any
  // register, and for immediate/absolute (PC autoincrement) addressing.
  function automatic logic ext_need(input logic [2:0] mode, input logic [2:0] rn);
    return (mode == 3'd6) || (mode == 3'd7) ||
           (((mode == 3'd2) || (mode == 3'd3)) && (rn == 3'd7));
  endfunction

  function automatic decode_t decode(input logic [15:0] ir);
    decode_t    d;
    logic       bw;
    logic [1:0] dst_n;
    bw        = ir[15];
    dst_n     = {1'b0, ext_need(ir[5:3], ir[2:0])};
    d.mnem    = OP_NOP;
    d.illegal = 1'b1;
    d.n_ext   = 2'd0;
    if ((ir[14:12] != 3'd0) && (ir[14:12] != 3'd7)) begin
      // double-operand group; source counted ahead of destination
      d.illegal = 1'b0;
      d.n_ext   = {1'b0, ext_need(ir[11:9], ir[8:6])} + dst_n;
      case (ir[14:12])
        3'd1:    d.mnem = bw ? OP_MOVB : OP_MOV;
        3'd2:    d.mnem = bw ? OP_CMPB : OP_CMP;
        3'd3:    d.mnem = bw ? OP_BITB : OP_BIT;
        3'd4:    d.mnem = bw ? OP_BICB : OP_BIC;
        3'd5:    d.mnem = bw ? OP_BISB : OP_BIS;
        3'd6:    d.mnem = bw ? OP_SUB  : OP_ADD;
        default: d.mnem = OP_NOP;
      endcase
    end else if (ir[14:12] == 3'd7) begin
      d.illegal = 1'b1;
    end else if ((ir[11] == 1'b0) && (bw || (ir[10:8] != 3'd0))) begin
      // branches: 0004xx..0037xx and 1000xx..1037xx
      d.illegal = 1'b0;
      case ({bw, ir[10:8]})
        4'b0001: d.mnem = OP_BR;
        4'b0010: d.mnem = OP_BNE;
        4'b0011: d.mnem = OP_BEQ;
        4'b0100: d.mnem = OP_BGE;
        4'b0101: d.mnem = OP_BLT;
        4'b0110: d.mnem = OP_BGT;
        4'b0111: d.mnem = OP_BLE;
        4'b1000: d.mnem = OP_BPL;
        4'b1001: d.mnem = OP_BMI;
        4'b1010: d.mnem = OP_BHI;
        4'b1011: d.mnem = OP_BLOS;
        4'b1100: d.mnem = OP_BVC;
        4'b1101: d.mnem = OP_BVS;
        4'b1110: d.mnem = OP_BCC;
        4'b1111: d.mnem = OP_BCS;
        default: d.mnem = OP_NOP;
      endcase
    end else if (!bw && (ir[11:8] == 4'd0)) begin
      // 0000xx..0003xx: HALT, JMP, RTS / condition codes, SWAB
      case (ir[7:6])
        2'd0: begin
          if (ir[5:0] == 6'o00) begin
            d.mnem    = OP_HALT;
            d.illegal = 1'b0;
          end else begin
            d.illegal = 1'b1;
          end
        end
        2'd1: begin
          // JMP to a register is meaningless
          if (ir[5:3] != 3'd0) begin
            d.mnem    = OP_JMP;
            d.illegal = 1'b0;
            d.n_ext   = dst_n;
          end else begin
            d.illegal = 1'b1;
          end
        end
        2'd2: begin
          d.illegal = 1'b0;
          if (ir[5:3] == 3'd0) begin
            d.mnem = OP_RTS;
          end else begin
            // only single-flag clear/set codes are accepted
            case (ir[5:0])
              6'o40:   d.mnem = OP_NOP;
              6'o41:   d.mnem = OP_CLC;
              6'o42:   d.mnem = OP_CLV;
              6'o44:   d.mnem = OP_CLZ;
              6'o50:   d.mnem = OP_CLN;
              6'o61:   d.mnem = OP_SEC;
              6'o62:   d.mnem = OP_SEV;
              6'o64:   d.mnem = OP_SEZ;
              6'o70:   d.mnem = OP_SEN;
              default: begin
                d.mnem    = OP_NOP;
                d.illegal = 1'b1;
              end
            endcase
          end
        end
        default: begin
          d.mnem    = OP_SWAB;
          d.illegal = 1'b0;
          d.n_ext   = dst_n;
        end
      endcase
    end else if (!bw && (ir[11:9] == 3'b100)) begin
      // JSR R,DD; register destination is illegal
      if (ir[5:3] != 3'd0) begin
        d.mnem    = OP_JSR;
        d.illegal = 1'b0;
        d.n_ext   = dst_n;
      end else begin
        d.illegal = 1'b1;
      end
    end else if ((ir[11:6] >= 6'o50) && (ir[11:6] <= 6'o63)) begin
      // single-operand group, bit 15 selects the byte form
      d.illegal = 1'b0;
      d.n_ext   = dst_n;
      case (ir[11:6])
        6'o50:   d.mnem = bw ? OP_CLRB : OP_CLR;
        6'o51:   d.mnem = bw ? OP_COMB : OP_COM;
        6'o52:   d.mnem = bw ? OP_INCB : OP_INC;
        6'o53:   d.mnem = bw ? OP_DECB : OP_DEC;
        6'o54:   d.mnem = bw ? OP_NEGB : OP_NEG;
        6'o55:   d.mnem = bw ? OP_ADCB : OP_ADC;
        6'o56:   d.mnem = bw ? OP_SBCB : OP_SBC;
        6'o57:   d.mnem = bw ? OP_TSTB : OP_TST;
        6'o60:   d.mnem = bw ? OP_RORB : OP_ROR;
        6'o61:   d.mnem = bw ? OP_ROLB : OP_ROL;
        6'o62:   d.mnem = bw ? OP_ASRB : OP_ASR;
        6'o63:   d.mnem = bw ? OP_ASLB : OP_ASL;
        default: d.mnem = OP_NOP;
      endcase
    end else begin
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  logic [2:0]     state_r;
  logic [15:0]    addr_r;
  logic [7:0]     lo_r;
  logic [15:0]    ipc_r;
  logic [1:0]     ext_left_r;
  logic           ext_idx_r;
  logic           mem_req_r;
  logic           valid_r;
  opcode_mnemonic mnem_r;
  logic [15:0]    ir_r;
  logic [15:0]    pc_r;
  logic [15:0]    next_pc_r;
  logic [15:0]    ext0_r;
  logic [15:0]    ext1_r;
  logic           illegal_r;

  logic           fetching_s;
  logic           ack_s;
  logic [15:0]    word_s;
  decode_t        dec_s;

  // acks only count while a request is actually outstanding
  assign fetching_s = (state_r == FETCH_LO) || (state_r == FETCH_HI) ||
                      (state_r == EXT_LO)   || (state_r == EXT_HI);
  assign ack_s      = mem_ack && mem_req_r && fetching_s;
  assign word_s     = {mem_rdata, lo_r};
  assign dec_s      = decode(word_s);

  // Fetch/decode state machine; a redirect overrides every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= FETCH_LO;
      addr_r     <= RESET_PC;
      lo_r       <= 8'd0;
      ipc_r      <= 16'd0;
      ext_left_r <= 2'd0;
      ext_idx_r  <= 1'b0;
      mem_req_r  <= 1'b0;
      valid_r    <= 1'b0;
      mnem_r     <= OP_HALT;
      ir_r       <= 16'd0;
      pc_r       <= 16'd0;
      next_pc_r  <= 16'd0;
      ext0_r     <= 16'd0;
      ext1_r     <= 16'd0;
      illegal_r  <= 1'b0;
    end else if (pc_load) begin
      // request drops for one cycle so the in-flight byte is discarded
      state_r   <= FETCH_LO;
      addr_r    <= {pc_load_val[15:1], 1'b0};
      mem_req_r <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      case (state_r)
        FETCH_LO: begin
          mem_req_r <= 1'b1;
          if (ack_s) begin
            lo_r    <= mem_rdata;
            ipc_r   <= addr_r;
            addr_r  <= addr_r + 16'd1;
            state_r <= FETCH_HI;
          end else begin
            state_r <= FETCH_LO;
          end
        end
        FETCH_HI: begin
          if (ack_s) begin
            ir_r       <= word_s;
            mnem_r     <= dec_s.mnem;
            illegal_r  <= dec_s.illegal;
            pc_r       <= ipc_r;
            next_pc_r  <= addr_r + 16'd1;
            ext0_r     <= 16'd0;
            ext1_r     <= 16'd0;
            ext_idx_r  <= 1'b0;
            ext_left_r <= dec_s.n_ext;
            addr_r     <= addr_r + 16'd1;
            if (dec_s.n_ext == 2'd0) begin
              state_r   <= HOLD;
              mem_req_r <= 1'b0;
              valid_r   <= 1'b1;
            end else begin
              state_r <= EXT_LO;
            end
          end else begin
            state_r <= FETCH_HI;
          end
        end
        EXT_LO: begin
          if (ack_s) begin
            lo_r    <= mem_rdata;
            addr_r  <= addr_r + 16'd1;
            state_r <= EXT_HI;
          end else begin
            state_r <= EXT_LO;
          end
        end
        EXT_HI: begin
          if (ack_s) begin
            if (ext_idx_r == 1'b0) begin
              ext0_r <= word_s;
            end else begin
              ext1_r <= word_s;
            end
            ext_idx_r  <= 1'b1;
            ext_left_r <= ext_left_r - 2'd1;
            next_pc_r  <= addr_r + 16'd1;
            addr_r     <= addr_r + 16'd1;
            if (ext_left_r == 2'd1) begin
              state_r   <= HOLD;
              mem_req_r <= 1'b0;
              valid_r   <= 1'b1;
            end else begin
              state_r <= EXT_LO;
            end
          end else begin
            state_r <= EXT_HI;
          end
        end
        HOLD: begin
          // addr_r already equals next_pc, so fetch resumes there
          if (dec_ready) begin
            valid_r   <= 1'b0;
            mem_req_r <= 1'b1;
            state_r   <= FETCH_LO;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          // unreachable encodings recover to an idle fetch
          state_r   <= FETCH_LO;
          mem_req_r <= 1'b0;
          valid_r   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = addr_r;
  assign mem_type    = 2'd2;
  assign dec_valid   = valid_r;
  assign dec_mnem    = mnem_r;
  assign dec_ir      = ir_r;
  assign dec_pc      = pc_r;
  assign dec_next_pc = next_pc_r;
  assign dec_ext0    = ext0_r;
  assign dec_ext1    = ext1_r;
  assign dec_illegal = illegal_r;

endmodule

// File: tb/tb_pdp_fetch_decode.sv
// Directed bench for pdp_fetch_decode: byte memory model with single-cycle
// ack, a read-address log, and a linear sequence of checked steps.
module tb_pdp_fetch_decode;
  import pdp_pkg::*;

  logic           clk;
  logic           rst;
  logic           pc_load;
  logic [15:0]    pc_load_val;
  logic           mem_req;
  logic [15:0]    mem_addr;
  logic [1:0]     mem_type;
  logic           mem_ack;
  logic [7:0]     mem_rdata;
  logic           dec_valid;
  logic           dec_ready;
  opcode_mnemonic dec_mnem;
  logic [15:0]    dec_ir;
  logic [15:0]    dec_pc;
  logic [15:0]    dec_next_pc;
  logic [15:0]    dec_ext0;
  logic [15:0]    dec_ext1;
  logic           dec_illegal;

  logic           ack_en;
  logic           ack_force;
  logic [7:0]     mem [0:65535];
  logic [15:0]    reads[$];

  int total = 0;
  int bad   = 0;

  pdp_fetch_decode #(.RESET_PC(16'o001000)) dut (
    .clk(clk), .rst(rst), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_type(mem_type),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_mnem(dec_mnem),
    .dec_ir(dec_ir), .dec_pc(dec_pc), .dec_next_pc(dec_next_pc),
    .dec_ext0(dec_ext0), .dec_ext1(dec_ext1), .dec_illegal(dec_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack   = ack_force | (mem_req & ack_en);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_ack) reads.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic put_word(input logic [15:0] a, input logic [15:0] w);
    mem[a]         = w[7:0];
    mem[a + 16'd1] = w[15:8];
  endtask

  function automatic logic [15:0] read_at(input int i);
    if (i < reads.size()) return reads[i];
    else return 16'hFFFF;
  endfunction

  task automatic wait_valid(input string tag);
    int n = 0;
    while (dec_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, dec_valid, 1);
  endtask

  task automatic wait_addr(input logic [15:0] a, input string tag);
    int n = 0;
    while (mem_addr !== a && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach"}, mem_addr, a);
  endtask

  task automatic accept();
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   mem_req, 0);
    chk({tag, "_addr"},  mem_addr, 16'o1000);
    chk({tag, "_valid"}, dec_valid, 0);
    chk({tag, "_mnem"},  dec_mnem, OP_HALT);
    chk({tag, "_ir"},    dec_ir, 0);
    chk({tag, "_pc"},    dec_pc, 0);
    chk({tag, "_npc"},   dec_next_pc, 0);
    chk({tag, "_ext"},   {dec_ext0, dec_ext1}, 0);
    chk({tag, "_ill"},   dec_illegal, 0);
  endtask

  initial begin
    rst = 1'b1; pc_load = 1'b0; pc_load_val = 16'd0; dec_ready = 1'b0;
    ack_en = 1'b1; ack_force = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'd0;
    put_word(16'o1000, 16'h15C0); put_word(16'o1002, 16'h0005);   // MOV #5,R0
    put_word(16'o1004, 16'h6C72); put_word(16'o1006, 16'h0002);   // ADD 2(R1),4(R2)
    put_word(16'o1010, 16'h0004);
    put_word(16'o1012, 16'h0007);                                 // illegal
    put_word(16'o1014, 16'h00A1);                                 // CLC
    put_word(16'o1016, 16'h6C72); put_word(16'o1020, 16'h0002);   // ADD, redirected away
    put_word(16'o1022, 16'h0004);
    put_word(16'o2000, 16'h0000);                                 // HALT
    put_word(16'o2002, 16'h00A1);

    // reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    chk("mem_type", mem_type, 2);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 16'o1000);

    // MOV #5,R0
    wait_valid("mov");
    chk("mov_mnem", dec_mnem, OP_MOV);
    chk("mov_ir", dec_ir, 16'h15C0);
    chk("mov_ext0", dec_ext0, 16'h0005);
    chk("mov_ext1", dec_ext1, 0);
    chk("mov_pc", dec_pc, 16'o1000);
    chk("mov_npc", dec_next_pc, 16'o1004);
    chk("mov_ill", dec_illegal, 0);
    chk("mov_nreads", reads.size(), 4);
    chk("mov_r0", read_at(0), 16'o1000);
    chk("mov_r3", read_at(3), 16'o1003);

    // stall in HOLD; stray acks must be ignored
    ack_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", dec_valid, 1);
      chk("hold_req", mem_req, 0);
      chk("hold_ir", dec_ir, 16'h15C0);
      chk("hold_addr", mem_addr, 16'o1004);
    end
    ack_force = 1'b0;
    reads.delete();
    accept();
    chk("acc_valid", dec_valid, 0);
    chk("acc_req", mem_req, 1);
    chk("acc_addr", mem_addr, 16'o1004);

    // ADD 2(R1),4(R2)
    wait_valid("add");
    chk("add_mnem", dec_mnem, OP_ADD);
    chk("add_ext0", dec_ext0, 16'h0002);
    chk("add_ext1", dec_ext1, 16'h0004);
    chk("add_pc", dec_pc, 16'o1004);
    chk("add_npc", dec_next_pc, 16'o1012);
    chk("add_nreads", reads.size(), 6);
    chk("add_r5", read_at(5), 16'o1011);

    // memory stall: address held until ack
    ack_en = 1'b0;
    accept();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 16'o1012);
    end
    ack_en = 1'b1;

    // 0x0007 illegal
    wait_valid("ill");
    chk("ill_flag", dec_illegal, 1);
    chk("ill_mnem", dec_mnem, OP_NOP);
    chk("ill_npc", dec_next_pc, 16'o1014);
    chk("ill_ext0", dec_ext0, 0);
    accept();

    // 0x00A1 CLC
    wait_valid("clc");
    chk("clc_mnem", dec_mnem, OP_CLC);
    chk("clc_ill", dec_illegal, 0);
    chk("clc_pc", dec_pc, 16'o1014);
    accept();

    // redirect during EXT_HI of the ADD at 1016
    wait_addr(16'o1021, "exthi");
    pc_load = 1'b1; pc_load_val = 16'o2001;
    @(negedge clk);
    pc_load = 1'b0;
    reads.delete();
    chk("redir_req", mem_req, 0);
    chk("redir_addr", mem_addr, 16'o2000);
    chk("redir_valid", dec_valid, 0);
    @(negedge clk);
    chk("redir_req2", mem_req, 1);
    wait_valid("halt");
    chk("halt_pc", dec_pc, 16'o2000);
    chk("halt_mnem", dec_mnem, OP_HALT);
    chk("halt_npc", dec_next_pc, 16'o2002);
    chk("halt_r0", read_at(0), 16'o2000);
    accept();

    // reset between FETCH_LO ack and FETCH_HI
    wait_addr(16'o2003, "midword");
    rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rerun_req", mem_req, 1);
    chk("rerun_addr", mem_addr, 16'o1000);
    wait_valid("mov2");
    chk("mov2_pc", dec_pc, 16'o1000);
    chk("mov2_ir", dec_ir, 16'h15C0);
    chk("mov2_ext0", dec_ext0, 16'h0005);

    // handshake and redirect in the same cycle; odd target is aligned
    dec_ready = 1'b1; pc_load = 1'b1; pc_load_val = 16'o1013;
    @(negedge clk);
    dec_ready = 1'b0; pc_load = 1'b0;
    chk("both_valid", dec_valid, 0);
    chk("both_req", mem_req, 0);
    chk("both_addr", mem_addr, 16'o1012);
    wait_valid("both");
    chk("both_pc", dec_pc, 16'o1012);
    chk("both_ill", dec_illegal, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
